// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch-stage state encoding and the default bubble instruction.
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  // Word-address increment; wraps FFFF_FFFF -> 0000_0000 by construction.
  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and the IF/ID output register.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic  stall;
  logic  branch_taken;
  word_t branch_target;
  word_t imem_addr;
  word_t imem_data;
  word_t out_PC;
  word_t out_instruction;
  logic  out_valid;

  modport master (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  imem_data,
    output imem_addr,
    output out_PC,
    output out_instruction,
    output out_valid
  );

  modport slave (
    output stall,
    output branch_taken,
    output branch_target,
    output imem_data,
    input  imem_addr,
    input  out_PC,
    input  out_instruction,
    input  out_valid
  );

endinterface

// File: rtl/fetch_perf_ctr.sv
// Saturating 32-bit event counter, cleared by synchronous reset and sticking at FFFF_FFFF.
module fetch_perf_ctr
  import cpu_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  en,
  output word_t count
);

  word_t count_q;
  word_t count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + word_t'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage for a synchronous IMEM: one-cycle boot, stall hold and branch redirect.
// Build macro FETCH_PERF_EN adds perf_fetch_count / perf_flush_count saturating counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master fif
`ifdef FETCH_PERF_EN
  ,
  output word_t        perf_fetch_count,
  output word_t        perf_flush_count
`endif
);

  fetch_state_e state_q, state_d;
  word_t        fetch_pc_q, fetch_pc_d;
  word_t        inflight_pc_q, inflight_pc_d;
  logic         inflight_valid_q, inflight_valid_d;
  word_t        hold_instr_q, hold_instr_d;
  word_t        out_pc_q, out_pc_d;
  word_t        out_instr_q, out_instr_d;
  logic         out_valid_q, out_valid_d;

  logic active;
  logic redirect;
  logic advance;

  // Redirects are only honoured once the boot cycle has primed the pipeline.
  assign active   = (state_q == ST_FETCH) || (state_q == ST_STALL);
  assign redirect = active && fif.branch_taken;
  assign advance  = active && !fif.branch_taken && !fif.stall;

  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    hold_instr_d     = hold_instr_q;
    out_pc_d         = out_pc_q;
    out_instr_d      = out_instr_q;
    out_valid_d      = out_valid_q;

    case (state_q)
      ST_BOOT: begin
        inflight_pc_d    = fetch_pc_q;
        inflight_valid_d = 1'b1;
        fetch_pc_d       = pc_inc(fetch_pc_q);
        state_d          = ST_FETCH;
      end

      ST_FETCH, ST_STALL: begin
        if (redirect) begin
          fetch_pc_d       = fif.branch_target;
          inflight_valid_d = 1'b0;
          out_valid_d      = 1'b0;
          out_instr_d      = NOP_INSTR;
          out_pc_d         = '0;
          state_d          = ST_FETCH;
        end else if (!advance) begin
          // The memory word only stays on imem_data for the first stalled cycle, so latch it there.
          if (state_q == ST_FETCH) begin
            hold_instr_d = fif.imem_data;
          end
          state_d = ST_STALL;
        end else begin
          out_instr_d      = (state_q == ST_STALL) ? hold_instr_q : fif.imem_data;
          out_pc_d         = inflight_pc_q;
          out_valid_d      = inflight_valid_q;
          inflight_pc_d    = fetch_pc_q;
          inflight_valid_d = 1'b1;
          fetch_pc_d       = pc_inc(fetch_pc_q);
          state_d          = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_BOOT;
      fetch_pc_q       <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
      hold_instr_q     <= NOP_INSTR;
      out_pc_q         <= '0;
      out_instr_q      <= NOP_INSTR;
      out_valid_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      hold_instr_q     <= hold_instr_d;
      out_pc_q         <= out_pc_d;
      out_instr_q      <= out_instr_d;
      out_valid_q      <= out_valid_d;
    end
  end

  assign fif.imem_addr       = fetch_pc_q;
  assign fif.out_PC          = out_pc_q;
  assign fif.out_instruction = out_instr_q;
  assign fif.out_valid       = out_valid_q;

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_fetch_ctr (
    .clock (clock),
    .reset (reset),
    .en    (advance && inflight_valid_q),
    .count (perf_fetch_count)
  );

  fetch_perf_ctr u_flush_ctr (
    .clock (clock),
    .reset (reset),
    .en    (redirect),
    .count (perf_flush_count)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected (PC, instruction) pairs plus directed checks.
// Covers boot latency, stall hold, redirect, stall+redirect priority, PC wrap, reset mid-stall, FETCH_PERF_EN counters.
module tb_fetch_unit;

  logic clock;
  logic reset;

  fetch_unit_if mif ();
  fetch_unit_if wif ();

`ifdef FETCH_PERF_EN
  logic [31:0] pf_fetch, pf_flush, pw_fetch, pw_flush;
`endif

  fetch_unit dut (
    .clock (clock),
    .reset (reset),
    .fif   (mif)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_count (pf_fetch),
    .perf_flush_count (pf_flush)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut_w (
    .clock (clock),
    .reset (reset),
    .fif   (wif)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_count (pw_fetch),
    .perf_flush_count (pw_flush)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction memory model: mem[a] = a + 0x100.
  always @(posedge clock) begin
    mif.imem_data <= mif.imem_addr + 32'h100;
    wif.imem_data <= wif.imem_addr + 32'h100;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_checks;
  int       n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_pc(input logic [31:0] pc);
    sb_item_t it;
    it.pc    = pc;
    it.instr = pc + 32'h100;
    sb_q.push_back(it);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic restart();
    reset = 1'b1;
    step();
    sb_q.delete();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: a new instruction is one that appears valid after a non-stalled, non-reset edge.
  logic     mon_stall, mon_rst;
  sb_item_t mon_exp;
  always @(posedge clock) begin
    mon_stall = mif.stall;
    mon_rst   = reset;
    #1;
    if (!mon_rst && !mon_stall && mif.out_valid) begin
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        check("sb_pc", mif.out_PC, mon_exp.pc);
        check("sb_instr", mif.out_instruction, mon_exp.instr);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    mif.stall = 1'b0; mif.branch_taken = 1'b0; mif.branch_target = '0;
    wif.stall = 1'b0; wif.branch_taken = 1'b0; wif.branch_target = '0;
    step();
    step();

    check("rst_valid", 32'(mif.out_valid), 32'd0);
    check("rst_pc", mif.out_PC, 32'h0);
    check("rst_instr", mif.out_instruction, 32'h0);
    check("rst_addr", mif.imem_addr, 32'h0);
    check("wrap_addr0", wif.imem_addr, 32'hFFFF_FFFE);

    // Sequential fetch with a 3-cycle stall while out_PC=5.
    for (int i = 0; i <= 8; i++) push_pc(32'(i));
    reset = 1'b0;
    step();
    check("boot_addr", mif.imem_addr, 32'h1);
    check("boot_valid", 32'(mif.out_valid), 32'd0);
    check("wrap_addr1", wif.imem_addr, 32'hFFFF_FFFF);
    step();
    check("first_valid", 32'(mif.out_valid), 32'd1);
    check("first_pc", mif.out_PC, 32'h0);
    check("first_instr", mif.out_instruction, 32'h100);
    check("seq_addr2", mif.imem_addr, 32'h2);
    check("wrap_addr2", wif.imem_addr, 32'h0000_0000);
    check("wrap_out_pc", wif.out_PC, 32'hFFFF_FFFE);
    check("wrap_out_instr", wif.out_instruction, 32'h0000_00FE);
    step();
    check("second_pc", mif.out_PC, 32'h1);
    check("second_instr", mif.out_instruction, 32'h101);
    repeat (4) step();
    check("pre_stall_pc", mif.out_PC, 32'h5);
    check("pre_stall_addr", mif.imem_addr, 32'h7);
    mif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_pc", mif.out_PC, 32'h5);
      check("stall_hold_instr", mif.out_instruction, 32'h105);
      check("stall_hold_addr", mif.imem_addr, 32'h7);
    end
    mif.stall = 1'b0;
    step();
    check("unstall_pc", mif.out_PC, 32'h6);
    check("unstall_instr", mif.out_instruction, 32'h106);
    step();
    step();
    check("seqA_drain", 32'(sb_q.size()), 32'd0);

    // Redirect to 0x40 while out_PC=3.
    restart();
    for (int i = 0; i <= 3; i++) push_pc(32'(i));
    push_pc(32'h40);
    push_pc(32'h41);
    repeat (5) step();
    check("br_pre_pc", mif.out_PC, 32'h3);
    mif.branch_taken = 1'b1;
    mif.branch_target = 32'h40;
    step();
    mif.branch_taken = 1'b0;
    check("br_bubble_valid", 32'(mif.out_valid), 32'd0);
    check("br_bubble_instr", mif.out_instruction, 32'h0);
    check("br_bubble_pc", mif.out_PC, 32'h0);
    check("br_addr", mif.imem_addr, 32'h40);
    step();
    check("br_bubble2_valid", 32'(mif.out_valid), 32'd0);
    step();
    check("br_tgt_valid", 32'(mif.out_valid), 32'd1);
    check("br_tgt_pc", mif.out_PC, 32'h40);
    check("br_tgt_instr", mif.out_instruction, 32'h140);
    step();
    check("br_drain", 32'(sb_q.size()), 32'd0);

    // Stall and redirect on the same edge, then two back-to-back redirects.
    restart();
    push_pc(32'h0);
    push_pc(32'h1);
    push_pc(32'h50);
    repeat (3) step();
    check("sb_pre_pc", mif.out_PC, 32'h1);
    mif.stall = 1'b1;
    mif.branch_taken = 1'b1;
    mif.branch_target = 32'h20;
    step();
    check("stbr_addr", mif.imem_addr, 32'h20);
    check("stbr_valid", 32'(mif.out_valid), 32'd0);
    mif.stall = 1'b0;
    mif.branch_target = 32'h30;
    step();
    check("br2_addr", mif.imem_addr, 32'h30);
    mif.branch_target = 32'h50;
    step();
    check("br3_addr", mif.imem_addr, 32'h50);
    mif.branch_taken = 1'b0;
    step();
    check("br3_bubble_valid", 32'(mif.out_valid), 32'd0);
    step();
    check("br3_tgt_pc", mif.out_PC, 32'h50);
    check("br3_tgt_instr", mif.out_instruction, 32'h150);
`ifdef FETCH_PERF_EN
    check("perf_flush", pf_flush, 32'd3);
    check("perf_fetch", pf_fetch, 32'd3);
`endif
    check("br3_drain", 32'(sb_q.size()), 32'd0);

    // Reset asserted while stalled must discard the held instruction.
    mif.stall = 1'b1;
    step();
    check("st_hold_pc", mif.out_PC, 32'h50);
    reset = 1'b1;
    step();
    check("rst_st_valid", 32'(mif.out_valid), 32'd0);
    check("rst_st_addr", mif.imem_addr, 32'h0);
    check("rst_st_instr", mif.out_instruction, 32'h0);
`ifdef FETCH_PERF_EN
    check("perf_flush_clr", pf_flush, 32'd0);
    check("perf_fetch_clr", pf_fetch, 32'd0);
`endif
    mif.stall = 1'b0;
    sb_q.delete();
    push_pc(32'h0);
    push_pc(32'h1);
    reset = 1'b0;
    step();
    step();
    check("post_rst_pc", mif.out_PC, 32'h0);
    check("post_rst_instr", mif.out_instruction, 32'h100);
    step();
    check("post_rst_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
